// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the CPU Memory stage and an external requester.
// The CPU has priority; a saturating wait counter bounds how long the external side can starve.
module dmem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  // A zero MAX_WAIT still needs a one-bit counter so the compare below stays legal.
  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t           state;
  state_t           stateNext;
  logic [CNT_W-1:0] waitCnt;
  logic             extElig;
  logic             gntExt;
  logic             gntCpu;

  // Handshake: the requester holds ext_req and its fields stable until ext_ack; the access
  // happens in the grant cycle and ext_ack pulses for exactly one cycle right after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      S_IDLE:  if (gntExt) stateNext = S_ACK;
      S_ACK:   stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  always_comb begin
    extElig = ext_req && (state == S_IDLE);
    gntExt  = extElig && (!cpu_req || (waitCnt == MAX_CNT));
    gntCpu  = cpu_req && !gntExt;
    ext_ack = (state == S_ACK);
  end

  // Port mux; with no winner the CPU fields pass through with the write disabled.
  always_comb begin
    mem_addr  = gntExt ? ext_addr  : cpu_addr;
    mem_wdata = gntExt ? ext_wdata : cpu_wdata;
    mem_we    = !rst && (gntExt ? ext_we : (gntCpu && cpu_we));
    cpu_stall = !rst && cpu_req && gntExt;
    cpu_rdata = mem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waitCnt <= '0;
    end else if (gntExt || !extElig) begin
      waitCnt <= '0;
    end else if (waitCnt != MAX_CNT) begin
      waitCnt <= waitCnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ext_rdata <= '0;
    else if (gntExt) ext_rdata <= mem_rdata;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: a MAX_WAIT=4 instance driven by a vector table plus reset
// sequences, and a MAX_WAIT=0 instance for the ext-always-wins case.
module tb_dmem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---- instance A (MAX_WAIT=4)
  logic        aCpuReq = 0, aCpuWe = 0, aExtReq = 0, aExtWe = 0;
  logic [31:0] aCpuAddr = 0, aCpuWdata = 0, aExtAddr = 0, aExtWdata = 0;
  logic [31:0] aCpuRdata, aExtRdata, aMemAddr, aMemWdata, aMemRdata;
  logic        aCpuStall, aExtAck, aMemWe;
  logic [31:0] memA [0:255];

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) u_a (
    .clk(clk), .rst(rst),
    .cpu_req(aCpuReq), .cpu_we(aCpuWe), .cpu_addr(aCpuAddr), .cpu_wdata(aCpuWdata),
    .cpu_rdata(aCpuRdata), .cpu_stall(aCpuStall),
    .ext_req(aExtReq), .ext_we(aExtWe), .ext_addr(aExtAddr), .ext_wdata(aExtWdata),
    .ext_rdata(aExtRdata), .ext_ack(aExtAck),
    .mem_addr(aMemAddr), .mem_wdata(aMemWdata), .mem_we(aMemWe), .mem_rdata(aMemRdata)
  );

  assign aMemRdata = memA[aMemAddr[7:0]];
  always @(posedge clk) begin
    if (rst) for (int i = 0; i < 256; i++) memA[i] <= '0;
    else if (aMemWe) memA[aMemAddr[7:0]] <= aMemWdata;
  end

  // ---- instance B (MAX_WAIT=0)
  logic        bCpuReq = 0, bCpuWe = 0, bExtReq = 0, bExtWe = 0;
  logic [31:0] bCpuAddr = 0, bCpuWdata = 0, bExtAddr = 0, bExtWdata = 0;
  logic [31:0] bCpuRdata, bExtRdata, bMemAddr, bMemWdata, bMemRdata;
  logic        bCpuStall, bExtAck, bMemWe;
  logic [31:0] memB [0:255];

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(0)) u_b (
    .clk(clk), .rst(rst),
    .cpu_req(bCpuReq), .cpu_we(bCpuWe), .cpu_addr(bCpuAddr), .cpu_wdata(bCpuWdata),
    .cpu_rdata(bCpuRdata), .cpu_stall(bCpuStall),
    .ext_req(bExtReq), .ext_we(bExtWe), .ext_addr(bExtAddr), .ext_wdata(bExtWdata),
    .ext_rdata(bExtRdata), .ext_ack(bExtAck),
    .mem_addr(bMemAddr), .mem_wdata(bMemWdata), .mem_we(bMemWe), .mem_rdata(bMemRdata)
  );

  assign bMemRdata = memB[bMemAddr[7:0]];
  always @(posedge clk) begin
    if (rst) for (int i = 0; i < 256; i++) memB[i] <= '0;
    else if (bMemWe) memB[bMemAddr[7:0]] <= bMemWdata;
  end

  // ---- scoreboard counters and compare
  int nTests = 0;
  int nFail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---- vector table: one record per cycle on instance A
  typedef struct {
    logic        cReq, cWe;
    logic [31:0] cAddr, cWdata;
    logic        eReq, eWe;
    logic [31:0] eAddr, eWdata;
    logic        xWe, xStall, xAck;
    logic        chkCr;
    logic [31:0] xCr;
    logic        chkEr;
    logic [31:0] xEr;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic cReq, input logic cWe, input logic [31:0] cAddr,
                              input logic [31:0] cWdata, input logic eReq, input logic eWe,
                              input logic [31:0] eAddr, input logic [31:0] eWdata,
                              input logic xWe, input logic xStall, input logic xAck,
                              input logic chkCr, input logic [31:0] xCr,
                              input logic chkEr, input logic [31:0] xEr);
    vec_t v;
    v.cReq = cReq; v.cWe = cWe; v.cAddr = cAddr; v.cWdata = cWdata;
    v.eReq = eReq; v.eWe = eWe; v.eAddr = eAddr; v.eWdata = eWdata;
    v.xWe = xWe; v.xStall = xStall; v.xAck = xAck;
    v.chkCr = chkCr; v.xCr = xCr; v.chkEr = chkEr; v.xEr = xEr;
    return v;
  endfunction

  task automatic driveA(input logic cReq, input logic cWe, input logic [31:0] cAddr,
                        input logic [31:0] cWdata, input logic eReq, input logic eWe,
                        input logic [31:0] eAddr, input logic [31:0] eWdata);
    aCpuReq = cReq; aCpuWe = cWe; aCpuAddr = cAddr; aCpuWdata = cWdata;
    aExtReq = eReq; aExtWe = eWe; aExtAddr = eAddr; aExtWdata = eWdata;
  endtask

  initial begin
    // CPU store / load, ext idle
    vecs[0]  = mk(1,1,32'h10,32'hDEADBEEF, 0,0,0,0,                1,0,0, 0,0, 0,0);
    vecs[1]  = mk(1,0,32'h10,0,            0,0,0,0,                0,0,0, 1,32'hDEADBEEF, 0,0);
    // ext write with CPU idle, ack the next cycle, CPU reads it back
    vecs[2]  = mk(0,0,0,0,                 1,1,32'h20,32'h12345678, 1,0,0, 0,0, 0,0);
    vecs[3]  = mk(0,0,0,0,                 1,1,32'h20,32'h12345678, 0,0,1, 0,0, 0,0);
    vecs[4]  = mk(0,0,0,0,                 0,0,0,0,                0,0,0, 0,0, 0,0);
    vecs[5]  = mk(1,0,32'h20,0,            0,0,0,0,                0,0,0, 1,32'h12345678, 0,0);
    // CPU busy every cycle, ext read forced through after MAX_WAIT cycles
    vecs[6]  = mk(1,0,32'h30,0,            1,0,32'h10,0,           0,0,0, 0,0, 0,0);
    vecs[7]  = mk(1,0,32'h30,0,            1,0,32'h10,0,           0,0,0, 0,0, 0,0);
    vecs[8]  = mk(1,0,32'h30,0,            1,0,32'h10,0,           0,0,0, 0,0, 0,0);
    vecs[9]  = mk(1,0,32'h30,0,            1,0,32'h10,0,           0,0,0, 0,0, 0,0);
    vecs[10] = mk(1,0,32'h30,0,            1,0,32'h10,0,           0,1,0, 1,32'hDEADBEEF, 0,0);
    vecs[11] = mk(1,0,32'h30,0,            1,0,32'h10,0,           0,0,1, 0,0, 1,32'hDEADBEEF);
    vecs[12] = mk(1,0,32'h30,0,            0,0,0,0,                0,0,0, 0,0, 0,0);
    // ext_req held across three writes, one access per two cycles
    vecs[13] = mk(0,0,0,0,                 1,1,32'h40,32'h11111111, 1,0,0, 0,0, 0,0);
    vecs[14] = mk(0,0,0,0,                 1,1,32'h40,32'h11111111, 0,0,1, 0,0, 0,0);
    vecs[15] = mk(0,0,0,0,                 1,1,32'h40,32'h22222222, 1,0,0, 0,0, 0,0);
    vecs[16] = mk(0,0,0,0,                 1,1,32'h40,32'h22222222, 0,0,1, 0,0, 1,32'h11111111);
    vecs[17] = mk(0,0,0,0,                 1,1,32'h40,32'h33333333, 1,0,0, 0,0, 0,0);
    vecs[18] = mk(0,0,0,0,                 1,1,32'h40,32'h33333333, 0,0,1, 0,0, 1,32'h22222222);
    vecs[19] = mk(1,0,32'h40,0,            0,0,0,0,                0,0,0, 1,32'h33333333, 0,0);

    // reset state with active requests on both sides
    driveA(1, 1, 32'h10, 32'hFFFFFFFF, 1, 1, 32'h20, 32'hFFFFFFFF);
    #12;
    check("reset mem_we", {31'd0, aMemWe}, 32'd0);
    check("reset cpu_stall", {31'd0, aCpuStall}, 32'd0);
    check("reset ext_ack", {31'd0, aExtAck}, 32'd0);
    check("reset ext_rdata", aExtRdata, 32'd0);
    @(negedge clk);
    driveA(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      driveA(vecs[i].cReq, vecs[i].cWe, vecs[i].cAddr, vecs[i].cWdata,
             vecs[i].eReq, vecs[i].eWe, vecs[i].eAddr, vecs[i].eWdata);
      #1;
      check($sformatf("v%0d mem_we", i), {31'd0, aMemWe}, {31'd0, vecs[i].xWe});
      check($sformatf("v%0d cpu_stall", i), {31'd0, aCpuStall}, {31'd0, vecs[i].xStall});
      check($sformatf("v%0d ext_ack", i), {31'd0, aExtAck}, {31'd0, vecs[i].xAck});
      if (vecs[i].chkCr) check($sformatf("v%0d cpu_rdata", i), aCpuRdata, vecs[i].xCr);
      if (vecs[i].chkEr) check($sformatf("v%0d ext_rdata", i), aExtRdata, vecs[i].xEr);
    end

    // reset while the ext side has waited three cycles under a CPU store stream
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      driveA(1, 1, 32'h50, 32'h00000001, 1, 0, 32'h10, 0);
    end
    @(negedge clk);
    #1;
    check("wait3 mem_we cpu store", {31'd0, aMemWe}, 32'd1);
    check("wait3 cpu_stall", {31'd0, aCpuStall}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rst wait mem_we", {31'd0, aMemWe}, 32'd0);
    check("rst wait cpu_stall", {31'd0, aCpuStall}, 32'd0);
    check("rst wait ext_ack", {31'd0, aExtAck}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("rewait c%0d cpu_stall", k), {31'd0, aCpuStall}, (k == 4) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    driveA(1, 1, 32'h50, 32'h00000002, 0, 0, 0, 0);
    #1;
    check("rewait ext_ack", {31'd0, aExtAck}, 32'd1);

    // reset during the ack cycle
    @(negedge clk);
    driveA(0, 0, 0, 0, 1, 0, 32'h50, 0);
    @(negedge clk);
    driveA(1, 1, 32'h60, 32'h00000003, 1, 0, 32'h50, 0);
    #1;
    check("ack before rst", {31'd0, aExtAck}, 32'd1);
    check("ack cycle cpu store", {31'd0, aMemWe}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst ack ext_ack", {31'd0, aExtAck}, 32'd0);
    check("rst ack ext_rdata", aExtRdata, 32'd0);
    check("rst ack mem_we", {31'd0, aMemWe}, 32'd0);
    @(negedge clk);
    driveA(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("no ack after rst", {31'd0, aExtAck}, 32'd0);

    // MAX_WAIT=0: ext wins a simultaneous request, CPU gets the port in the ack cycle
    @(negedge clk);
    bCpuReq = 1; bCpuWe = 1; bCpuAddr = 32'h08; bCpuWdata = 32'hAAAA5555;
    bExtReq = 1; bExtWe = 1; bExtAddr = 32'h04; bExtWdata = 32'h5555AAAA;
    #1;
    check("mw0 t cpu_stall", {31'd0, bCpuStall}, 32'd1);
    check("mw0 t mem_we", {31'd0, bMemWe}, 32'd1);
    check("mw0 t mem_addr", bMemAddr, 32'h04);
    check("mw0 t ext_ack", {31'd0, bExtAck}, 32'd0);
    @(negedge clk);
    #1;
    check("mw0 t+1 cpu_stall", {31'd0, bCpuStall}, 32'd0);
    check("mw0 t+1 mem_addr", bMemAddr, 32'h08);
    check("mw0 t+1 mem_we", {31'd0, bMemWe}, 32'd1);
    check("mw0 t+1 ext_ack", {31'd0, bExtAck}, 32'd1);
    @(negedge clk);
    bExtReq = 0; bCpuWe = 0; bCpuAddr = 32'h04;
    #1;
    check("mw0 readback ext", bCpuRdata, 32'h5555AAAA);
    @(negedge clk);
    bCpuAddr = 32'h08;
    #1;
    check("mw0 readback cpu", bCpuRdata, 32'hAAAA5555);
    check("mw0 ext_ack idle", {31'd0, bExtAck}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
